mem_ring_client: RTL and testbench
==================================

# mem_ring_client

Per-core ring interface that turns a core's 128-bit line read/write requests into ring messages for the coherent memory multiplexer, and collects read-return data from the separate read-data path. Sits between a core's cache-miss logic and the ring, one instance per core, directly upstream of the memory multiplexer on the ring. It holds at most one pending request and sends one request per token visit. It tracks outstanding reads and reassembles four 32-bit return words into one line.

## Interface
- `CORE_ID`, 4'd1: this node's ring source ID. 0 is reserved for the memory and must not be used.
- `MAX_OUTSTANDING`, 4: maximum reads in flight, in the range 1..15.
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `RingIn`  in  32  ring data from the upstream node.
- `SlotTypeIn`  in  4  slot type from upstream.
- `SourceIn`  in  4  source ID from upstream.
- `RingOut`  out  32  ring data to the downstream node.
- `SlotTypeOut`  out  4  slot type downstream.
- `SourceOut`  out  4  source ID downstream.
- `RDreturn`  in  32  read-return word from memory.
- `RDdest`  in  4  destination of the `RDreturn` word. 0 means none.
- `req_valid`  in  1  the core presents a request.
- `req_ready`  out  1  the block accepts the request in this cycle.
- `req_write`  in  1  1 = write line, 0 = read line.
- `req_addr`  in  26  line address.
- `req_wdata`  in  128  write data. Word 0 is `[31:0]`.
- `rsp_valid`  out  1  one-cycle pulse: read line complete.
- `rsp_data`  out  128  assembled line. Word 0 is `[31:0]`.
- `outstanding`  out  4  number of reads in flight.
- `proto_err`  out  1  sticky protocol-error flag.

## Operation
- Reset values:
  - all ring outputs are 0, with slot type `Null`;
  - `req_ready`, `rsp_valid`, `rsp_data`, `outstanding` and `proto_err` are all 0;
  - the holding register is empty;
  - the FSM is in `IDLE`.
- Accept rule: a request is accepted when `req_valid & req_ready`. It is latched into the one-entry holding register.
- `req_ready` is asserted when the holding register is empty and either `req_write` is 1 or `outstanding < MAX_OUTSTANDING`.
- FSM states: `IDLE`, `SEND_ADDR`, `SEND_WD` (word counter 0..3), `RELEASE`.
  - `IDLE` with an incoming `Token` and the holding register full: capture the token, drive slot type `Null`, data 0, source 0, and go to `SEND_ADDR`.
  - `IDLE` in every other case: pass all inputs through unchanged.
  - `SEND_ADDR`: emit slot type `Address`, `RingOut = {3'b000, ~write, 2'b00, addr}` (bit 31 = 0), `SourceOut = CORE_ID`.
    - For a read, increment `outstanding` and go to `RELEASE`.
    - For a write, go to `SEND_WD`.
  - `SEND_WD`: emit slot type `WriteData` with words w0, w1, w2, w3 in order and `SourceOut = CORE_ID`. Go to `RELEASE` after w3.
  - `RELEASE`: emit `Token` with data 0 and source 0, empty the holding register, and go to `IDLE`.
- While the FSM is out of `IDLE`, upstream slots are overwritten. Any incoming slot that is not `Null` sets `proto_err`.
- Incoming `Token` in `IDLE` with the holding register empty: forward it in the same cycle (combinational pass-through).
- Read return:
  - Every cycle with `RDdest == CORE_ID` stores `RDreturn` into word slot `rcnt` (2 bits) and increments `rcnt`.
  - On the 4th word, `rsp_valid` pulses on the next cycle with the full line, and `outstanding` decrements.
  - A return word arriving while `outstanding == 0` sets `proto_err` and is dropped.
- Simultaneous events:
  - If an Address-read send and an `rsp_valid` decrement fall in the same cycle, `outstanding` is unchanged.
  - A request accept and `RELEASE` in the same cycle is not possible, because `req_ready` needs the holding register to be empty.
- Reset mid-operation: all state is cleared immediately, including a held token, `rcnt` and `outstanding`. Token regeneration is the memory multiplexer's responsibility after reset.

## Timing
- The token arrives in cycle T:
  - T: output `Null`.
  - T+1: `Address`.
  - Read: `Token` at T+2.
  - Write: `WriteData` in T+2..T+5, `Token` at T+6.
- The token is held for 2 ring cycles on a read and 6 on a write. The next request can be accepted at T+3 for a read, T+7 for a write.
- Return path: 4th word at cycle R gives `rsp_valid` at R+1. `outstanding` is updated at R+1.
- Ring outputs in `IDLE` are combinational from the inputs, with zero-cycle pass-through. In the other states they are registered-state decodes.

## Structure
- Shared package/include: the slot-type constants (`Token`, `Address`, `WriteData`, `Null`), the address-word field positions (bit 31 reserved-nullify, bit 28 = read), and the memory source ID 0.
- One natural sub-module, `rd_line_assembler`: the `RDdest` match, `rcnt`, the 4×32 register file and the `rsp_valid` pulse. The FSM and the outstanding counter stay at top level.

## Test plan
- Read: accept addr 26'h0000123, then Token in → `Null`, then `Address` 32'h10000123 with source `CORE_ID`, then `Token`. `outstanding` = 1.
- Write: addr 26'h0000040, wdata words 1,2,3,4, then Token in → `Null`, then `Address` 32'h00000040, then `WriteData` 1,2,3,4, then `Token`. `outstanding` stays 0.
- Return: 4 words 0xA,0xB,0xC,0xD on `RDdest = CORE_ID`, interleaved with words for other IDs → one `rsp_valid` with `rsp_data` = {D,C,B,A}. `outstanding` decrements.
- Backpressure: with `MAX_OUTSTANDING = 2`, issue 2 reads → `req_ready` = 0 for a read and 1 for a write. A same-cycle send and return leaves the count unchanged.
- Passthrough and errors: with no request pending, a Token and foreign Address/WriteData slots pass unchanged. A non-`Null` slot while holding the token → `proto_err` = 1 (sticky).
- Reset asserted at T+3 of a write → the next cycle shows all outputs at their reset values, `Null` on the ring, and the holding register empty.

Source files
------------

// File: rtl/mem_ring_client_pkg.sv
// Shared ring encodings for the memory ring client: slot types, address-word
// field positions, the reserved memory source ID and the client FSM states.
package mem_ring_client_pkg;

  localparam logic [3:0] SLOT_NULL       = 4'd0;
  localparam logic [3:0] SLOT_TOKEN      = 4'd1;
  localparam logic [3:0] SLOT_ADDRESS    = 4'd2;
  localparam logic [3:0] SLOT_WRITE_DATA = 4'd3;

  localparam int ADDR_NULLIFY_BIT = 31;
  localparam int ADDR_READ_BIT    = 28;

  localparam logic [3:0] MEM_SOURCE_ID = 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    SEND_ADDR,
    SEND_WD,
    RELEASE
  } ringState_e;

  // Bit 31 (nullify) stays clear; bit 28 flags a read.
  function automatic logic [31:0] addrWord(input logic isWrite, input logic [25:0] addr);
    logic [31:0] word;
    word                = '0;
    word[ADDR_READ_BIT] = ~isWrite;
    word[25:0]          = addr;
    return word;
  endfunction

endpackage

// File: rtl/mem_ring_client_rd_line_assembler.sv
// Collects four read-return words addressed to this node into one 128-bit line
// and pulses rsp_valid the cycle after the fourth word lands.
module rd_line_assembler
  import mem_ring_client_pkg::*;
#(
  parameter logic [3:0] CORE_ID = 4'd1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  RDreturn,
  input  logic [3:0]   RDdest,
  input  logic         acceptEnable,
  output logic         destHit,
  output logic         lineDone,
  output logic         rsp_valid,
  output logic [127:0] rsp_data
);

  logic [1:0]        rcnt_q;
  logic [3:0][31:0]  line_q;
  logic              rspValid_q;
  logic              wordAccept;

  assign destHit    = (RDdest == CORE_ID) && (RDdest != MEM_SOURCE_ID);
  assign wordAccept = destHit && acceptEnable;
  assign lineDone   = wordAccept && (rcnt_q == 2'd3);

  always_ff @(posedge clock) begin
    if (reset) begin
      rcnt_q     <= '0;
      line_q     <= '0;
      rspValid_q <= 1'b0;
    end else begin
      rspValid_q <= lineDone;
      if (wordAccept) begin
        line_q[rcnt_q] <= RDreturn;
        rcnt_q         <= rcnt_q + 2'd1;
      end
    end
  end

  assign rsp_valid = rspValid_q;
  assign rsp_data  = line_q;

endmodule

// File: rtl/mem_ring_client.sv
// Per-core ring client: holds one line request, sends it on a token visit and
// tracks reads in flight until their return lines are assembled.
module mem_ring_client
  import mem_ring_client_pkg::*;
#(
  parameter logic [3:0] CORE_ID         = 4'd1,
  parameter int         MAX_OUTSTANDING = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  RingIn,
  input  logic [3:0]   SlotTypeIn,
  input  logic [3:0]   SourceIn,
  output logic [31:0]  RingOut,
  output logic [3:0]   SlotTypeOut,
  output logic [3:0]   SourceOut,
  input  logic [31:0]  RDreturn,
  input  logic [3:0]   RDdest,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [25:0]  req_addr,
  input  logic [127:0] req_wdata,
  output logic         rsp_valid,
  output logic [127:0] rsp_data,
  output logic [3:0]   outstanding,
  output logic         proto_err
);

  localparam logic [3:0] MAX_COUNT = 4'(MAX_OUTSTANDING);

  ringState_e       state_q;
  logic [1:0]       wcnt_q;
  logic             holdValid_q;
  logic             holdWrite_q;
  logic [25:0]      holdAddr_q;
  logic [3:0][31:0] holdData_q;
  logic [3:0]       outstanding_q;
  logic             protoErr_q;

  logic tokenCapture;
  logic accept;
  logic readSent;
  logic destHit;
  logic lineDone;

  assign tokenCapture = (state_q == IDLE) && (SlotTypeIn == SLOT_TOKEN) && holdValid_q;
  assign req_ready    = !reset && !holdValid_q && (req_write || (outstanding_q < MAX_COUNT));
  assign accept       = req_valid && req_ready;
  assign readSent     = (state_q == SEND_ADDR) && !holdWrite_q;

  rd_line_assembler #(
    .CORE_ID(CORE_ID)
  ) u_rd_line_assembler (
    .clock       (clock),
    .reset       (reset),
    .RDreturn    (RDreturn),
    .RDdest      (RDdest),
    .acceptEnable(outstanding_q != 4'd0),
    .destHit     (destHit),
    .lineDone    (lineDone),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data)
  );

  // IDLE is a zero-latency pass-through; every other state owns the slot.
  always_comb begin
    RingOut     = '0;
    SlotTypeOut = SLOT_NULL;
    SourceOut   = '0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (!tokenCapture) begin
            RingOut     = RingIn;
            SlotTypeOut = SlotTypeIn;
            SourceOut   = SourceIn;
          end
        end
        SEND_ADDR: begin
          RingOut     = addrWord(holdWrite_q, holdAddr_q);
          SlotTypeOut = SLOT_ADDRESS;
          SourceOut   = CORE_ID;
        end
        SEND_WD: begin
          RingOut     = holdData_q[wcnt_q];
          SlotTypeOut = SLOT_WRITE_DATA;
          SourceOut   = CORE_ID;
        end
        RELEASE: begin
          SlotTypeOut = SLOT_TOKEN;
        end
        default: begin
          SlotTypeOut = SLOT_NULL;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      wcnt_q        <= '0;
      holdValid_q   <= 1'b0;
      holdWrite_q   <= 1'b0;
      holdAddr_q    <= '0;
      holdData_q    <= '0;
      outstanding_q <= '0;
      protoErr_q    <= 1'b0;
    end else begin
      if (accept) begin
        holdValid_q <= 1'b1;
        holdWrite_q <= req_write;
        holdAddr_q  <= req_addr;
        holdData_q  <= req_wdata;
      end
      case (state_q)
        IDLE: begin
          if (tokenCapture) state_q <= SEND_ADDR;
        end
        SEND_ADDR: begin
          wcnt_q  <= '0;
          state_q <= holdWrite_q ? SEND_WD : RELEASE;
        end
        SEND_WD: begin
          wcnt_q <= wcnt_q + 2'd1;
          if (wcnt_q == 2'd3) state_q <= RELEASE;
        end
        RELEASE: begin
          holdValid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if ((state_q != IDLE) && (SlotTypeIn != SLOT_NULL)) protoErr_q <= 1'b1;
      if (destHit && (outstanding_q == 4'd0)) protoErr_q <= 1'b1;
      // A read send and a completed line in the same cycle cancel out.
      case ({readSent, lineDone})
        2'b10:   outstanding_q <= outstanding_q + 4'd1;
        2'b01:   outstanding_q <= outstanding_q - 4'd1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  assign outstanding = outstanding_q;
  assign proto_err   = protoErr_q;

endmodule

// File: tb/tb_mem_ring_client.sv
// Scoreboard bench for mem_ring_client: ring slots and returned lines are
// queued as expectations when driven and checked when the DUT emits them.
module tb_mem_ring_client;
  import mem_ring_client_pkg::*;

  localparam logic [3:0] CORE_ID = 4'd1;

  logic         clock;
  logic         reset;
  logic [31:0]  RingIn;
  logic [3:0]   SlotTypeIn;
  logic [3:0]   SourceIn;
  logic [31:0]  RingOut;
  logic [3:0]   SlotTypeOut;
  logic [3:0]   SourceOut;
  logic [31:0]  RDreturn;
  logic [3:0]   RDdest;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [25:0]  req_addr;
  logic [127:0] req_wdata;
  logic         rsp_valid;
  logic [127:0] rsp_data;
  logic [3:0]   outstanding;
  logic         proto_err;

  int totalChecks = 0;
  int badChecks   = 0;

  logic [35:0]  ringQ[$];
  logic [127:0] rspQ[$];

  mem_ring_client #(
    .CORE_ID        (CORE_ID),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .RingIn     (RingIn),
    .SlotTypeIn (SlotTypeIn),
    .SourceIn   (SourceIn),
    .RingOut    (RingOut),
    .SlotTypeOut(SlotTypeOut),
    .SourceOut  (SourceOut),
    .RDreturn   (RDreturn),
    .RDdest     (RDdest),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .outstanding(outstanding),
    .proto_err  (proto_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] slot, input logic [3:0] src, input logic [31:0] data);
    SlotTypeIn = slot;
    SourceIn   = src;
    RingIn     = data;
  endtask

  task automatic sendReturn(input logic [3:0] dest, input logic [31:0] word);
    tick();
    RDdest   = dest;
    RDreturn = word;
  endtask

  task automatic issueRequest(input logic w, input logic [25:0] a, input logic [127:0] d);
    int waitCycles;
    tick();
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    waitCycles = 0;
    forever begin
      @(negedge clock);
      if (req_ready) break;
      waitCycles++;
      if (waitCycles > 20) begin
        checkOutput("req_ready timeout", {127'd0, req_ready}, 128'd1);
        break;
      end
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic runToken(input logic w, input logic [25:0] a, input logic [127:0] d);
    if (w) ringQ.push_back({SLOT_ADDRESS, 6'b000000, a});
    else   ringQ.push_back({SLOT_ADDRESS, 6'b000100, a});
    if (w) for (int i = 0; i < 4; i++) ringQ.push_back({SLOT_WRITE_DATA, d[i*32 +: 32]});
    tick();
    applyStimulus(SLOT_TOKEN, 4'd0, 32'd0);
    @(negedge clock);
    checkOutput("token capture", {SlotTypeOut, SourceOut, RingOut}, {SLOT_NULL, 4'd0, 32'd0});
    tick();
    applyStimulus(SLOT_NULL, 4'd0, 32'd0);
    repeat (w ? 5 : 1) @(negedge clock);
    @(negedge clock);
    checkOutput("token release", {SlotTypeOut, SourceOut, RingOut}, {SLOT_TOKEN, 4'd0, 32'd0});
  endtask

  task automatic returnLine(input logic [127:0] line);
    rspQ.push_back(line);
    for (int i = 0; i < 4; i++) sendReturn(CORE_ID, line[i*32 +: 32]);
    sendReturn(4'd0, 32'd0);
  endtask

  always @(negedge clock) begin
    if (!reset && SourceOut == CORE_ID &&
        (SlotTypeOut == SLOT_ADDRESS || SlotTypeOut == SLOT_WRITE_DATA)) begin
      if (ringQ.size() == 0) checkOutput("ring unexpected", {92'd0, SlotTypeOut, RingOut}, 128'd0);
      else checkOutput("ring slot", {92'd0, SlotTypeOut, RingOut}, {92'd0, ringQ.pop_front()});
    end
    if (!reset && rsp_valid) begin
      if (rspQ.size() == 0) checkOutput("rsp unexpected", rsp_data, 128'd0);
      else checkOutput("rsp line", rsp_data, rspQ.pop_front());
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    RDdest    = '0;
    RDreturn  = '0;
    applyStimulus(SLOT_TOKEN, 4'd3, 32'h1111_2222);
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reset ring", {SlotTypeOut, SourceOut, RingOut}, {SLOT_NULL, 4'd0, 32'd0});
    checkOutput("reset ready", {127'd0, req_ready}, 128'd0);
    checkOutput("reset rsp", {rsp_valid, rsp_data}, 129'd0);
    checkOutput("reset outstanding/err", {outstanding, proto_err}, 5'd0);
    tick();
    reset = 1'b0;
    applyStimulus(SLOT_NULL, 4'd0, 32'd0);
    @(negedge clock);
    checkOutput("ready after reset", {127'd0, req_ready}, 128'd1);

    // Read request
    issueRequest(1'b0, 26'h0000123, 128'd0);
    checkOutput("outstanding before read", outstanding, 4'd0);
    runToken(1'b0, 26'h0000123, 128'd0);
    checkOutput("outstanding after read", outstanding, 4'd1);

    // Write request
    issueRequest(1'b1, 26'h0000040, {32'd4, 32'd3, 32'd2, 32'd1});
    runToken(1'b1, 26'h0000040, {32'd4, 32'd3, 32'd2, 32'd1});
    checkOutput("outstanding after write", outstanding, 4'd1);

    // Return interleaved with foreign destinations
    rspQ.push_back({32'hD, 32'hC, 32'hB, 32'hA});
    sendReturn(CORE_ID, 32'hA);
    sendReturn(4'd3, 32'h99);
    sendReturn(CORE_ID, 32'hB);
    sendReturn(4'd0, 32'h77);
    sendReturn(CORE_ID, 32'hC);
    sendReturn(4'd2, 32'h55);
    sendReturn(CORE_ID, 32'hD);
    sendReturn(4'd0, 32'd0);
    @(negedge clock);
    checkOutput("rsp_valid pulse", {127'd0, rsp_valid}, 128'd1);
    checkOutput("outstanding after line", outstanding, 4'd0);
    @(negedge clock);
    checkOutput("rsp_valid one cycle", {127'd0, rsp_valid}, 128'd0);

    // Backpressure at two reads in flight
    issueRequest(1'b0, 26'h0000200, 128'd0);
    runToken(1'b0, 26'h0000200, 128'd0);
    issueRequest(1'b0, 26'h3FFFFFF, 128'd0);
    runToken(1'b0, 26'h3FFFFFF, 128'd0);
    checkOutput("outstanding at max", outstanding, 4'd2);
    tick();
    req_write = 1'b0;
    @(negedge clock);
    checkOutput("ready read at max", {127'd0, req_ready}, 128'd0);
    tick();
    req_write = 1'b1;
    @(negedge clock);
    checkOutput("ready write at max", {127'd0, req_ready}, 128'd1);
    tick();
    req_write = 1'b0;
    returnLine({32'h13, 32'h12, 32'h11, 32'h10});
    @(negedge clock);
    checkOutput("outstanding drained one", outstanding, 4'd1);

    // Read send and line completion in the same cycle
    issueRequest(1'b0, 26'h0ABCDEF, 128'd0);
    ringQ.push_back({SLOT_ADDRESS, 6'b000100, 26'h0ABCDEF});
    rspQ.push_back({32'h23, 32'h22, 32'h21, 32'h20});
    sendReturn(CORE_ID, 32'h20);
    sendReturn(CORE_ID, 32'h21);
    sendReturn(CORE_ID, 32'h22);
    tick();
    RDdest = 4'd0;
    applyStimulus(SLOT_TOKEN, 4'd0, 32'd0);
    @(negedge clock);
    checkOutput("simul capture", {SlotTypeOut, SourceOut, RingOut}, {SLOT_NULL, 4'd0, 32'd0});
    tick();
    applyStimulus(SLOT_NULL, 4'd0, 32'd0);
    RDdest   = CORE_ID;
    RDreturn = 32'h23;
    tick();
    RDdest = 4'd0;
    @(negedge clock);
    checkOutput("simul outstanding", outstanding, 4'd1);
    checkOutput("simul release", {SlotTypeOut, SourceOut, RingOut}, {SLOT_TOKEN, 4'd0, 32'd0});
    returnLine({32'h33, 32'h32, 32'h31, 32'h30});
    @(negedge clock);
    checkOutput("outstanding empty", outstanding, 4'd0);

    // Pass-through with nothing pending
    tick();
    applyStimulus(SLOT_TOKEN, 4'd0, 32'd0);
    @(negedge clock);
    checkOutput("pass token", {SlotTypeOut, SourceOut, RingOut}, {SLOT_TOKEN, 4'd0, 32'd0});
    tick();
    applyStimulus(SLOT_ADDRESS, 4'd5, 32'h1234_5678);
    @(negedge clock);
    checkOutput("pass address", {SlotTypeOut, SourceOut, RingOut}, {SLOT_ADDRESS, 4'd5, 32'h1234_5678});
    tick();
    applyStimulus(SLOT_WRITE_DATA, 4'd7, 32'hCAFE_F00D);
    @(negedge clock);
    checkOutput("pass wdata", {SlotTypeOut, SourceOut, RingOut}, {SLOT_WRITE_DATA, 4'd7, 32'hCAFE_F00D});
    checkOutput("no err yet", {127'd0, proto_err}, 128'd0);
    tick();
    applyStimulus(SLOT_NULL, 4'd0, 32'd0);

    // Foreign slot while holding the token
    issueRequest(1'b1, 26'h0000155, {32'h44, 32'h33, 32'h22, 32'h11});
    ringQ.push_back({SLOT_ADDRESS, 6'b000000, 26'h0000155});
    for (int i = 1; i <= 4; i++) ringQ.push_back({SLOT_WRITE_DATA, 32'(i * 32'h11)});
    tick();
    applyStimulus(SLOT_TOKEN, 4'd0, 32'd0);
    tick();
    applyStimulus(SLOT_ADDRESS, 4'd5, 32'hDEAD);
    @(negedge clock);
    checkOutput("err not yet", {127'd0, proto_err}, 128'd0);
    tick();
    applyStimulus(SLOT_NULL, 4'd0, 32'd0);
    @(negedge clock);
    checkOutput("err set", {127'd0, proto_err}, 128'd1);
    repeat (3) @(negedge clock);
    @(negedge clock);
    checkOutput("err release", {SlotTypeOut, SourceOut, RingOut}, {SLOT_TOKEN, 4'd0, 32'd0});
    repeat (2) @(negedge clock);
    checkOutput("err sticky", {127'd0, proto_err}, 128'd1);

    // Reset in the middle of a write burst
    issueRequest(1'b1, 26'h0000077, {32'h8, 32'h7, 32'h6, 32'h5});
    ringQ.push_back({SLOT_ADDRESS, 6'b000000, 26'h0000077});
    ringQ.push_back({SLOT_WRITE_DATA, 32'h5});
    tick();
    applyStimulus(SLOT_TOKEN, 4'd0, 32'd0);
    tick();
    applyStimulus(SLOT_NULL, 4'd0, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    checkOutput("post reset ring", {SlotTypeOut, SourceOut, RingOut}, {SLOT_NULL, 4'd0, 32'd0});
    checkOutput("post reset rsp", {rsp_valid, rsp_data}, 129'd0);
    checkOutput("post reset outstanding/err", {outstanding, proto_err}, 5'd0);
    checkOutput("post reset hold empty", {127'd0, req_ready}, 128'd1);
    tick();
    applyStimulus(SLOT_TOKEN, 4'd0, 32'd0);
    @(negedge clock);
    checkOutput("post reset idle pass", {SlotTypeOut, SourceOut, RingOut}, {SLOT_TOKEN, 4'd0, 32'd0});
    tick();
    applyStimulus(SLOT_NULL, 4'd0, 32'd0);

    // Return word with nothing in flight is dropped and flagged
    sendReturn(CORE_ID, 32'h55);
    sendReturn(4'd0, 32'd0);
    @(negedge clock);
    checkOutput("drop err", {127'd0, proto_err}, 128'd1);
    checkOutput("drop no rsp", {124'd0, outstanding}, 128'd0);

    repeat (2) @(negedge clock);
    checkOutput("ringQ drained", 128'(ringQ.size()), 128'd0);
    checkOutput("rspQ drained", 128'(rspQ.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
